// File: rtl/burst_mem_resp.sv
// burst_mem_resp
//   Memory-side responder for the burst read/write request interface of the
//   cache fetch controller. Serves one burst at a time: grants it, sinks write
//   beats into an internal word array or streams read beats out of it, and
//   signals completion with wr_done / rd_done.
//
// Ports
//   clk, rst                       clock (rising edge), async active-high reset
//   wr_req/wr_gnt/wr_len/wr_addr   write burst request, grant, byte length, word address
//   wr_data/wr_valid/wr_last/wr_ready  write beat channel
//   wr_done                        one-cycle write-complete pulse
//   rd_req/rd_gnt/rd_len/rd_addr   read burst request, grant, byte length, word address
//   rd_data/rd_valid/rd_done/rd_ready  read beat channel (rd_data registered)
//   busy                           a burst is in progress
//   err                            sticky write-length mismatch flag
module burst_mem_resp #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int MEM_DEPTH  = 1024,
    parameter int READ_LAT   = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_req,
    output logic                  wr_gnt,
    input  logic [15:0]           wr_len,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  wr_valid,
    input  logic                  wr_last,
    output logic                  wr_ready,
    output logic                  wr_done,
    input  logic                  rd_req,
    output logic                  rd_gnt,
    input  logic [15:0]           rd_len,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    output logic                  rd_done,
    input  logic                  rd_ready,
    output logic                  busy,
    output logic                  err
);

    localparam int BYTE_SHIFT = $clog2(DATA_WIDTH / 8);
    localparam int IDX_W      = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam int LAT_W      = (READ_LAT > 2) ? $clog2(READ_LAT) : 1;

    typedef enum logic [2:0] {
        IDLE,
        WR_DATA,
        WR_RESP,
        RD_WAIT,
        RD_DATA
    } state_t;

    state_t                state_q, state_d;
    logic [IDX_W-1:0]      base_q, base_d;
    logic [15:0]           beats_q, beats_d;
    logic [15:0]           beat_q, beat_d;
    logic [LAT_W-1:0]      lat_q, lat_d;
    logic                  err_q, err_d;
    logic [DATA_WIDTH-1:0] rd_data_q;

    logic                  mem_we;
    logic [IDX_W-1:0]      mem_widx;
    logic                  rd_load;
    logic [IDX_W-1:0]      rd_idx;

    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

    // Upper address bits and sub-word length bits do not affect indexing.
    logic unused_bits;
    assign unused_bits = ^{wr_addr, rd_addr, wr_len, rd_len};

    // Byte length to beat count; a zero-length burst still moves one beat.
    function automatic logic [15:0] len_to_beats(input logic [15:0] len);
        logic [15:0] b;
        b = len >> BYTE_SHIFT;
        return (b == 16'd0) ? 16'd1 : b;
    endfunction

    always_comb begin
        state_d  = state_q;
        base_d   = base_q;
        beats_d  = beats_q;
        beat_d   = beat_q;
        lat_d    = lat_q;
        err_d    = err_q;
        wr_gnt   = 1'b0;
        rd_gnt   = 1'b0;
        wr_ready = 1'b0;
        wr_done  = 1'b0;
        rd_valid = 1'b0;
        rd_done  = 1'b0;
        mem_we   = 1'b0;
        mem_widx = base_q + IDX_W'(beat_q);
        rd_load  = 1'b0;
        rd_idx   = base_q;

        unique case (state_q)
            IDLE: begin
                // Grants are combinational, so hold them low while in reset.
                if (!rst && wr_req) begin
                    wr_gnt  = 1'b1;
                    base_d  = wr_addr[IDX_W-1:0];
                    beats_d = len_to_beats(wr_len);
                    beat_d  = '0;
                    state_d = WR_DATA;
                end else if (!rst && rd_req) begin
                    rd_gnt  = 1'b1;
                    base_d  = rd_addr[IDX_W-1:0];
                    beats_d = len_to_beats(rd_len);
                    beat_d  = '0;
                    lat_d   = '0;
                    // With a one-cycle latency the first word is fetched at the grant edge.
                    if (READ_LAT == 1) begin
                        rd_load = 1'b1;
                        rd_idx  = rd_addr[IDX_W-1:0];
                        state_d = RD_DATA;
                    end else begin
                        state_d = RD_WAIT;
                    end
                end
            end

            WR_DATA: begin
                wr_ready = 1'b1;
                if (wr_valid) begin
                    beat_d = beat_q + 16'd1;
                    // Overrun beats are acknowledged but dropped.
                    if (beat_q < beats_q) mem_we = 1'b1;
                    else                  err_d  = 1'b1;
                    if (wr_last) begin
                        if (beat_q + 16'd1 != beats_q) err_d = 1'b1;
                        state_d = WR_RESP;
                    end
                end
            end

            WR_RESP: begin
                wr_done = 1'b1;
                state_d = IDLE;
            end

            RD_WAIT: begin
                // Fetch issued on the last wait cycle so rd_valid rises READ_LAT after grant.
                if (lat_q == LAT_W'(READ_LAT - 2)) begin
                    rd_load = 1'b1;
                    rd_idx  = base_q;
                    state_d = RD_DATA;
                end else begin
                    lat_d = lat_q + 1'b1;
                end
            end

            RD_DATA: begin
                rd_valid = 1'b1;
                rd_done  = (beat_q == beats_q - 16'd1);
                if (rd_ready) begin
                    beat_d = beat_q + 16'd1;
                    if (rd_done) begin
                        state_d = IDLE;
                    end else begin
                        rd_load = 1'b1;
                        rd_idx  = base_q + IDX_W'(beat_q + 16'd1);
                    end
                end
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            base_q    <= '0;
            beats_q   <= '0;
            beat_q    <= '0;
            lat_q     <= '0;
            err_q     <= 1'b0;
            rd_data_q <= '0;
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
            beats_q <= beats_d;
            beat_q  <= beat_d;
            lat_q   <= lat_d;
            err_q   <= err_d;
            if (rd_load) rd_data_q <= mem[rd_idx];
        end
    end

    // Array contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (mem_we) mem[mem_widx] <= wr_data;
    end

    assign rd_data = rd_data_q;
    assign err     = err_q;
    assign busy    = (state_q != IDLE);

endmodule

// File: tb/tb_burst_mem_resp.sv
// tb_burst_mem_resp
//   Directed self-checking bench for burst_mem_resp with default parameters
//   (32-bit words, 1024-word array, READ_LAT 2). A per-cycle vector table
//   covers grant arbitration and a short write/read; hand-written sequences
//   cover long bursts, read stalls, length errors, wrap and mid-burst reset.
module tb_burst_mem_resp;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_req, wr_gnt, wr_valid, wr_last, wr_ready, wr_done;
    logic [15:0] wr_len, rd_len;
    logic [31:0] wr_addr, wr_data, rd_addr, rd_data;
    logic        rd_req, rd_gnt, rd_valid, rd_done, rd_ready, busy, err;

    int errors = 0;
    int checks = 0;

    burst_mem_resp #(
        .ADDR_WIDTH(32),
        .DATA_WIDTH(32),
        .MEM_DEPTH (1024),
        .READ_LAT  (2)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .wr_req  (wr_req),
        .wr_gnt  (wr_gnt),
        .wr_len  (wr_len),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .wr_valid(wr_valid),
        .wr_last (wr_last),
        .wr_ready(wr_ready),
        .wr_done (wr_done),
        .rd_req  (rd_req),
        .rd_gnt  (rd_gnt),
        .rd_len  (rd_len),
        .rd_addr (rd_addr),
        .rd_data (rd_data),
        .rd_valid(rd_valid),
        .rd_done (rd_done),
        .rd_ready(rd_ready),
        .busy    (busy),
        .err     (err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic        wr_req;
        logic        rd_req;
        logic        wr_valid;
        logic        wr_last;
        logic        rd_ready;
        logic [15:0] len;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [6:0]  exp;      // {wr_gnt, rd_gnt, wr_ready, wr_done, rd_valid, rd_done, busy}
        logic        chk_data;
        logic [31:0] exp_data;
    } vec_t;

    vec_t vecs [9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [15:0] len, input int n,
                            input logic [31:0] base, input logic exp_err);
        wr_req  = 1'b1;
        wr_addr = addr;
        wr_len  = len;
        #1 chk("wr_gnt", 32'(wr_gnt), 32'd1);
        tick();
        wr_req = 1'b0;
        for (int i = 0; i < n; i++) begin
            wr_valid = 1'b1;
            wr_data  = base + 32'(i);
            wr_last  = (i == n - 1);
            #1 chk("wr_ready", 32'(wr_ready), 32'd1);
            tick();
        end
        wr_valid = 1'b0;
        wr_last  = 1'b0;
        #1 chk("wr_done", 32'(wr_done), 32'd1);
        chk("wr_err", 32'(err), 32'(exp_err));
        tick();
        #1 chk("wr_done_pulse", 32'(wr_done), 32'd0);
        chk("wr_idle", 32'(busy), 32'd0);
    endtask

    task automatic do_read(input logic [31:0] addr, input logic [15:0] len, input int n,
                           input logic [31:0] base);
        rd_req  = 1'b1;
        rd_addr = addr;
        rd_len  = len;
        #1 chk("rd_gnt", 32'(rd_gnt), 32'd1);
        tick();
        rd_req   = 1'b0;
        rd_ready = 1'b1;
        #1 chk("rd_latency", 32'(rd_valid), 32'd0);
        tick();
        for (int i = 0; i < n; i++) begin
            #1 chk("rd_valid", 32'(rd_valid), 32'd1);
            chk("rd_data", rd_data, base + 32'(i));
            chk("rd_done", 32'(rd_done), 32'(i == n - 1));
            tick();
        end
        #1 chk("rd_end_valid", 32'(rd_valid), 32'd0);
        chk("rd_end_busy", 32'(busy), 32'd0);
        rd_ready = 1'b0;
    endtask

    initial begin
        int k;

        rst = 1'b1;
        wr_req = 1'b0; wr_valid = 1'b0; wr_last = 1'b0; wr_len = '0; wr_addr = '0; wr_data = '0;
        rd_req = 1'b0; rd_ready = 1'b0; rd_len = '0; rd_addr = '0;

        vecs[0] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'd8, 32'h200, 32'h0,        7'b1000000, 1'b0, 32'h0};
        vecs[1] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'd8, 32'h200, 32'hAAAA0001, 7'b0010001, 1'b0, 32'h0};
        vecs[2] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 16'd8, 32'h200, 32'hAAAA0002, 7'b0010001, 1'b0, 32'h0};
        vecs[3] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'd8, 32'h200, 32'h0,        7'b0001001, 1'b0, 32'h0};
        vecs[4] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'd8, 32'h200, 32'h0,        7'b0100000, 1'b0, 32'h0};
        vecs[5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'd8, 32'h200, 32'h0,        7'b0000001, 1'b0, 32'h0};
        vecs[6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'd8, 32'h200, 32'h0,        7'b0000101, 1'b1, 32'hAAAA0001};
        vecs[7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'd8, 32'h200, 32'h0,        7'b0000111, 1'b1, 32'hAAAA0002};
        vecs[8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd8, 32'h200, 32'h0,        7'b0000000, 1'b0, 32'h0};

        // Reset state
        tick();
        tick();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_rd_valid", 32'(rd_valid), 32'd0);
        chk("rst_rd_data", rd_data, 32'h0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_wr_ready", 32'(wr_ready), 32'd0);
        chk("rst_wr_done", 32'(wr_done), 32'd0);
        rst = 1'b0;
        tick();

        // Vector table: simultaneous requests, write wins, read granted after wr_done
        foreach (vecs[i]) begin
            wr_req   = vecs[i].wr_req;
            rd_req   = vecs[i].rd_req;
            wr_valid = vecs[i].wr_valid;
            wr_last  = vecs[i].wr_last;
            rd_ready = vecs[i].rd_ready;
            wr_len   = vecs[i].len;
            rd_len   = vecs[i].len;
            wr_addr  = vecs[i].addr;
            rd_addr  = vecs[i].addr;
            wr_data  = vecs[i].wdata;
            #1;
            chk($sformatf("vec%0d_ctl", i),
                32'({wr_gnt, rd_gnt, wr_ready, wr_done, rd_valid, rd_done, busy}), 32'(vecs[i].exp));
            if (vecs[i].chk_data) chk($sformatf("vec%0d_data", i), rd_data, vecs[i].exp_data);
            tick();
        end

        // 128B write and read back at 0x40
        do_write(32'h40, 16'd128, 32, 32'h1000, 1'b0);
        do_read(32'h40, 16'd128, 32, 32'h1000);

        // Read with rd_ready toggling: every stalled cycle must show the same beat
        rd_req  = 1'b1;
        rd_addr = 32'h40;
        rd_len  = 16'd32;
        #1 chk("stall_gnt", 32'(rd_gnt), 32'd1);
        tick();
        rd_req = 1'b0;
        k = 0;
        for (int c = 0; c < 40 && k < 8; c++) begin
            rd_ready = (c % 2 == 1);
            #1;
            if (rd_valid) begin
                chk("stall_data", rd_data, 32'h1000 + 32'(k));
                chk("stall_done", 32'(rd_done), 32'(k == 7));
                if (rd_ready) k++;
            end
            tick();
        end
        chk("stall_beats", 32'(k), 32'd8);
        rd_ready = 1'b0;
        #1 chk("stall_end_valid", 32'(rd_valid), 32'd0);

        // Short write against a 128B length sets err; err stays set afterwards
        do_write(32'h300, 16'd128, 16, 32'h5000, 1'b1);
        do_write(32'd1022, 16'd16, 4, 32'h7000, 1'b1);
        // Read across the top of the array wraps to index 0
        do_read(32'd1022, 16'd16, 4, 32'h7000);
        chk("err_sticky", 32'(err), 32'd1);

        // Asynchronous reset in the middle of a read burst
        rd_req  = 1'b1;
        rd_addr = 32'h40;
        rd_len  = 16'd128;
        #1 chk("mid_gnt", 32'(rd_gnt), 32'd1);
        tick();
        rd_req   = 1'b0;
        rd_ready = 1'b1;
        tick();
        for (int i = 0; i < 5; i++) tick();
        #1 chk("mid_beat5", rd_data, 32'h1005);
        chk("mid_valid", 32'(rd_valid), 32'd1);
        rst = 1'b1;
        #1 chk("arst_valid", 32'(rd_valid), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_err", 32'(err), 32'd0);
        chk("arst_data", rd_data, 32'h0);
        tick();
        rst      = 1'b0;
        rd_ready = 1'b0;
        tick();
        do_read(32'h300, 16'd8, 2, 32'h5000);
        do_read(32'h40, 16'd16, 4, 32'h1000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
